// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage data-memory interface running one outstanding req/ready/rvalid access,
// with byte-lane strobes, replicated store data, load extension and a timeout abort.
module load_store_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [6:0]  mem_control,
  input  logic        mem_to_reg,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        access_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q, f3;
  logic [1:0]       off_q;
  logic             req_q, we_q, load_valid_q, bus_err_q;
  logic [31:0]      addr_q, wdata_q, load_data_q, wdata_d, load_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic             is_st, start, legal, mis, ok, idle, last, unused;
  assign unused = ^mem_control[5:3];
  assign f3     = mem_control[2:0];
  assign is_st  = mem_control[6];
  assign start  = req_valid & (is_st | mem_to_reg);
  assign legal  = is_st ? f3 < 3'd3 : (f3 < 3'd3 || f3 == 3'd4 || f3 == 3'd5);
  assign mis    = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign ok     = legal & ~mis;
  assign idle   = state_q == IDLE;
  assign last   = cnt_q == CNT_W'(TIMEOUT - 1);
  assign access_err = idle & start & ~ok;
  assign stall      = (idle & start & ok) | state_q == REQ | state_q == RESP;
  assign wstrb_d = !is_st ? 4'h0 : f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0]
                 : f3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'hF;
  assign wdata_d = f3[1:0] == 2'b00 ? {4{store_data[7:0]}}
                 : f3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  // lane select uses the offset captured at issue, not the live address
  assign byte_v = 8'(dmem_rdata >> {off_q, 3'b000});
  assign half_v = 16'(dmem_rdata >> {off_q[1], 4'b0000});
  assign load_d = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_v[7]}}, byte_v}
                : f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_v[15]}}, half_v} : dmem_rdata;
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign bus_err    = bus_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: if (start && ok) begin
          state_q <= REQ;
          req_q   <= 1'b1;
          we_q    <= is_st;
          addr_q  <= {addr[31:2], 2'b00};
          wdata_q <= wdata_d;
          wstrb_q <= wstrb_d;
          f3_q    <= f3;
          off_q   <= addr[1:0];
          cnt_q   <= '0;
        end
        REQ: if (dmem_ready) begin
          req_q   <= 1'b0;
          state_q <= we_q ? DONE : RESP;
        end else if (last) begin
          req_q       <= 1'b0;
          state_q     <= DONE;
          bus_err_q   <= 1'b1;
          load_data_q <= '0;
        end
        RESP: if (dmem_rvalid) begin
          load_data_q  <= load_d;
          load_valid_q <= 1'b1;
          state_q      <= DONE;
        end else if (last) begin
          state_q     <= DONE;
          bus_err_q   <= 1'b1;
          load_data_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
